is42vm16400k_model: RTL and testbench
=====================================

# is42vm16400k_model

Cycle-based, synthesizable model of a 64 Mb x16 SDR SDRAM (4 banks x 4096 rows x 256 columns x 16 bit). It sits on the board-side pins of the SDRAM controller, `sdrc_top`, in the 16-bit configuration, in place of a vendor behavioural model. It decodes the standard SDR command set and stores data in an internal array. It returns read data on the bidirectional `dq` bus with programmable CAS latency and burst length.

## Interface
- ROW_BITS, 12: row address width (rows per bank = 2^ROW_BITS).
- COL_BITS, 8: column address width (page = 2^COL_BITS words).
- DQ_BITS, 16: data width; byte lanes = DQ_BITS/8.
- clk  in  1  clock; all sampling on the rising edge.
- rst  in  1  reset; synchronous, active-high.
- cke  in  1  clock enable.
- csb  in  1  chip select, active low.
- rasb  in  1  RAS, active low.
- casb  in  1  CAS, active low.
- web  in  1  write enable, active low.
- ba  in  2  bank address.
- addr  in  ROW_BITS  row, or column plus A10 flag.
- dqm  in  DQ_BITS/8  byte mask, active high.
- dq  inout  DQ_BITS  data; high-Z unless read data is driven.

## Operation
- Reset (rst=1 at edge):
  - all banks idle, no burst in progress.
  - dq high-Z.
  - mode register = 13'h033: BL=8, sequential, CL=3, burst write.
  - array contents are unchanged.
- cke=0 at an edge: inputs are ignored and all state, including burst and pipeline, is frozen. Power-down and self-refresh are not modelled.
- Command decode {csb,rasb,casb,web} at an edge with cke=1:
  - 1xxx or 0111: NOP.
  - 0011: ACTIVE. Opens row `addr` in bank `ba`.
  - 0101: READ. Column = addr[COL_BITS-1:0]; A10=1 means auto-precharge.
  - 0100: WRITE. Column and A10 as for READ.
  - 0010: PRECHARGE. Closes bank `ba`; A10=1 closes all banks.
  - 0001: AUTO REFRESH. No data effect; ignored unless all banks are idle.
  - 0000: LOAD MODE. mode ← addr. Ignored unless all banks are idle.
  - 0110: BURST TERMINATE.
- Mode register decode:
  - [2:0] burst length: 0→1, 1→2, 2→4, 3→8, 7→full page.
  - [3] burst type: 0 sequential, 1 interleaved.
  - [6:4] CAS latency: 2 or 3. Other values are treated as 3.
  - [9] write mode: 1 means single-word writes regardless of BL.
- Burst address for beat i, with base column c and BL=2^k:
  - Sequential: upper bits c[COL_BITS-1:k] fixed, low k bits = (c[k-1:0]+i) mod BL.
  - Interleaved: low k bits = c[k-1:0] XOR i.
  - Full page: (c+i) mod 2^COL_BITS; continues until interrupted.
- READ/WRITE to an idle bank is ignored: no data, and dq stays Z.
- A new READ or WRITE truncates any active burst, and the new burst starts immediately.
- PRECHARGE of the bursting bank, or BURST TERMINATE, ends the burst:
  - Writes stop at that edge.
  - Reads already issued into the CL pipeline complete; no further beats are issued.
- Auto-precharge: the bank returns to idle after the last beat of the burst.
- Timing parameters (tRCD, tRP, tRAS, tRC, tWR, refresh interval) are not checked. Commands take effect as issued.

## Timing
- Write:
  - Beat 0 is sampled from dq at the WRITE edge; beat i at edge +i.
  - dqm[b]=1 on the same edge leaves byte b of that word unchanged.
- Read:
  - READ at edge n: beat i is driven on dq from edge n+CL-1+i until edge n+CL+i, so it is valid at edge n+CL+i.
  - After the last beat, dq returns to Z.
- Read DQM latency is 2: dqm sampled high at edge m forces dq=Z for the beat sampled at edge m+2. Masking is whole-word: the word is Z if any dqm bit is set.
- Write during a read pipeline: a WRITE at edge w cancels all read beats not yet driven, and dq is Z from edge w.
- Simultaneous events:
  - A READ at the last beat edge of a prior read continues seamlessly with no gap.
  - rst at any edge overrides every command and empties the read pipeline.
- Array write and array read of the same word at the same edge: the read returns the old data.

## Test plan
- Reset, then LOAD MODE 0x033; ACTIVE bank 1 row 0x012; WRITE col 0x04 with data 0x1111..0x8888 → READ col 0x04 returns the same 8 words, the first at READ edge +3, with dq Z before and after.
- Same pattern with READ col 0x06 → sequential wrap order 0x06,07,00,01,02,03,04,05. Mode 0x03B (interleaved) reading col 0x06 → order 6,7,4,5,2,3,0,1.
- WRITE 0xABCD with dqm=2'b10 over a word holding 0x1234 → read back 0x12CD. A read with dqm high at edge m → that beat is Z at edge m+2.
- Mode 0x023 (CL=2): READ at edge n → first word valid at n+2. A READ issued 4 cycles after the previous one → 8+4 contiguous beats, with the first burst truncated after 4.
- READ with A10=1, then READ the same bank without ACTIVE → the second read is ignored and dq stays Z.
- Assert rst mid-read burst → dq is Z from the next edge; mode returns to 0x033; previously written data is retained.

Source files
------------

// File: rtl/is42vm16400k_model_if.sv
// Command/address/mask pins of the SDR SDRAM as seen from the controller side.
interface is42vm16400k_model_if #(
  parameter int ROW_BITS = 12,
  parameter int DQ_BITS  = 16
);
  logic                 cke;
  logic                 csb;
  logic                 rasb;
  logic                 casb;
  logic                 web;
  logic [1:0]           ba;
  logic [ROW_BITS-1:0]  addr;
  logic [DQ_BITS/8-1:0] dqm;

  modport master (output cke, csb, rasb, casb, web, ba, addr, dqm);
  modport slave  (input  cke, csb, rasb, casb, web, ba, addr, dqm);
endinterface

// File: rtl/is42vm16400k_model.sv
// Cycle-based SDR SDRAM model: command decode, per-bank open rows, one burst engine
// shared by reads and writes, and a CL-deep read pipeline that drives dq.
module is42vm16400k_model #(
  parameter int ROW_BITS = 12,
  parameter int COL_BITS = 8,
  parameter int DQ_BITS  = 16
) (
  input  logic                clk,
  input  logic                rst,
  is42vm16400k_model_if.slave bus,
  inout  wire  [DQ_BITS-1:0]  dq
);
  localparam int NB = DQ_BITS / 8;
  localparam int AW = 2 + ROW_BITS + COL_BITS;

  typedef enum logic [2:0] {C_NOP, C_ACT, C_RD, C_WR, C_PRE, C_REF, C_LMR, C_BT} op_e;

  op_e                 op;
  logic [ROW_BITS-1:0] mode;
  logic [3:0]          bank_open;
  logic [ROW_BITS-1:0] bank_row [4];
  logic                bst_act, bst_wr, bst_ap, bst_full, bst_il;
  logic [1:0]          bst_bank;
  logic [COL_BITS-1:0] bst_col, bst_cnt, bst_mask;
  logic                new_bst, stop, beat, b_wr, b_ap, b_full, b_il, b_last, cl2;
  logic [1:0]          b_bank;
  logic [COL_BITS-1:0] b_col, b_i, b_mask, b_colx, m_mask;
  logic [AW-1:0]       b_addr;
  logic [DQ_BITS-1:0]  mem [2**AW];
  logic [1:0]          vld_pipe;
  logic [DQ_BITS-1:0]  dat_pipe [2];
  logic                dqm_q, out_oe;
  logic [DQ_BITS-1:0]  out_dat;

  wire unused_mode = &{1'b0, mode[ROW_BITS-1:10], mode[8:7]};

  always_comb begin
    op = C_NOP;
    if (!bus.csb) begin
      case ({bus.rasb, bus.casb, bus.web})
        3'b011:  op = C_ACT;
        3'b101:  op = C_RD;
        3'b100:  op = C_WR;
        3'b010:  op = C_PRE;
        3'b001:  op = C_REF;
        3'b000:  op = C_LMR;
        3'b110:  op = C_BT;
        default: op = C_NOP;
      endcase
    end
  end

  // Beat selection: a fresh READ/WRITE wins, otherwise the running burst continues
  // unless this edge terminates it.
  always_comb begin
    case (mode[2:0])
      3'd1:    m_mask = COL_BITS'(1);
      3'd2:    m_mask = COL_BITS'(3);
      3'd3:    m_mask = COL_BITS'(7);
      3'd7:    m_mask = '1;
      default: m_mask = '0;
    endcase
    new_bst = (op == C_RD || op == C_WR) && bank_open[bus.ba];
    stop    = bst_act && (op == C_BT ||
              (op == C_PRE && (bus.addr[10] || bus.ba == bst_bank)));
    beat    = new_bst || (bst_act && !stop);
    if (new_bst) begin
      b_wr   = (op == C_WR);
      b_bank = bus.ba;
      b_col  = bus.addr[COL_BITS-1:0];
      b_i    = '0;
      b_ap   = bus.addr[10];
      b_il   = mode[3];
      b_full = (mode[2:0] == 3'd7) && !(b_wr && mode[9]);
      b_mask = (b_wr && mode[9]) ? '0 : m_mask;
    end else begin
      b_wr   = bst_wr;
      b_bank = bst_bank;
      b_col  = bst_col;
      b_i    = bst_cnt;
      b_ap   = bst_ap;
      b_il   = bst_il;
      b_full = bst_full;
      b_mask = bst_mask;
    end
    b_last = !b_full && (b_i == b_mask);
    if (b_il && !b_full) b_colx = (b_col & ~b_mask) | ((b_col ^ b_i) & b_mask);
    else                 b_colx = (b_col & ~b_mask) | ((b_col + b_i) & b_mask);
    b_addr = {b_bank, bank_row[b_bank], b_colx};
    cl2    = (mode[6:4] == 3'd2);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mode      <= ROW_BITS'('h033);
      bank_open <= '0;
      bst_act   <= 1'b0;
      vld_pipe  <= '0;
      out_oe    <= 1'b0;
      dqm_q     <= 1'b0;
    end else if (bus.cke) begin
      dqm_q <= |bus.dqm;
      case (op)
        C_ACT: bank_open[bus.ba] <= 1'b1;
        C_PRE: if (bus.addr[10]) bank_open <= '0;
               else              bank_open[bus.ba] <= 1'b0;
        C_LMR: if (bank_open == '0) mode <= bus.addr;
        default: ;
      endcase
      if (beat) begin
        bst_act  <= !b_last;
        bst_wr   <= b_wr;
        bst_bank <= b_bank;
        bst_col  <= b_col;
        bst_cnt  <= b_i + COL_BITS'(1);
        bst_ap   <= b_ap;
        bst_il   <= b_il;
        bst_full <= b_full;
        bst_mask <= b_mask;
        if (b_last && b_ap) bank_open[b_bank] <= 1'b0;
      end else begin
        bst_act <= 1'b0;
      end
      // A new WRITE flushes read beats that have not reached the pins yet.
      if (op == C_WR && new_bst) begin
        vld_pipe <= '0;
        out_oe   <= 1'b0;
      end else begin
        vld_pipe <= {vld_pipe[0], beat && !b_wr};
        out_oe   <= (cl2 ? vld_pipe[0] : vld_pipe[1]) && !dqm_q;
      end
    end
  end

  // Array and data path; the array read sees pre-write contents on a same-edge collision.
  always_ff @(posedge clk) begin
    if (bus.cke && !rst) begin
      if (op == C_ACT) bank_row[bus.ba] <= bus.addr;
      if (beat && b_wr) begin
        for (int b = 0; b < NB; b++)
          if (!bus.dqm[b]) mem[b_addr][b*8 +: 8] <= dq[b*8 +: 8];
      end
      dat_pipe[0] <= mem[b_addr];
      dat_pipe[1] <= dat_pipe[0];
      out_dat     <= cl2 ? dat_pipe[0] : dat_pipe[1];
    end
  end

  assign dq = out_oe ? out_dat : {DQ_BITS{1'bz}};
endmodule

// File: tb/tb_is42vm16400k_model.sv
// Directed bench for the SDRAM model; dq is pulled up so an undriven bus reads as 16'hFFFF.
module tb_is42vm16400k_model;
  localparam logic [3:0]  NOP = 4'b0111, ACT = 4'b0011, RD = 4'b0101, WR = 4'b0100;
  localparam logic [3:0]  PRE = 4'b0010, LMR = 4'b0000, BT = 4'b0110;
  localparam logic [15:0] ZV  = 16'hFFFF;

  logic        clk   = 1'b0;
  logic        rst   = 1'b1;
  logic        tb_oe = 1'b0;
  logic [15:0] tb_dq = '0;
  wire  [15:0] dq;
  int          checks = 0;
  int          failures = 0;

  is42vm16400k_model_if #(.ROW_BITS(12), .DQ_BITS(16)) bus ();

  is42vm16400k_model #(.ROW_BITS(12), .COL_BITS(8), .DQ_BITS(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus),
    .dq  (dq)
  );

  pullup pu_dq (dq);
  assign dq = tb_oe ? tb_dq : 16'hzzzz;

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Applies one command at a negedge and returns at the negedge after the next rising edge.
  task automatic drive(input logic [3:0] c, input logic [1:0] b, input logic [11:0] a,
                       input logic [1:0] m, input logic oe, input logic [15:0] d);
    {bus.csb, bus.rasb, bus.casb, bus.web} = c;
    bus.ba   = b;
    bus.addr = a;
    bus.dqm  = m;
    tb_oe    = oe;
    tb_dq    = d;
    @(negedge clk);
  endtask

  task automatic cmd(input logic [3:0] c, input logic [1:0] b, input logic [11:0] a);
    drive(c, b, a, 2'b00, 1'b0, 16'h0);
  endtask

  task automatic nopm(input logic m);
    drive(NOP, 2'd0, 12'h0, {2{m}}, 1'b0, 16'h0);
  endtask

  // Called right after a READ edge: Z until beat 0 at READ+lat, nb beats, then Z.
  // dqm is raised on the edge numbered mk after the READ (-1 for none).
  task automatic expect_seq(input string tag, input int lat, input int nb,
                            input logic [15:0] e [8], input int mk);
    int k;
    k = 0;
    chk($sformatf("%s_z0", tag), dq, ZV);
    for (int j = 1; j < lat - 1; j++) begin
      k++; nopm(k == mk);
      chk($sformatf("%s_pre%0d", tag, j), dq, ZV);
    end
    for (int i = 0; i < nb; i++) begin
      k++; nopm(k == mk);
      chk($sformatf("%s_b%0d", tag, i), dq, e[i]);
    end
    k++; nopm(k == mk);
    chk($sformatf("%s_post", tag), dq, ZV);
  endtask

  initial begin
    logic [15:0] e [8];
    logic [15:0] t [12];
    logic [15:0] x;
    bus.cke = 1'b1;
    {bus.csb, bus.rasb, bus.casb, bus.web} = NOP;
    bus.ba = '0; bus.addr = '0; bus.dqm = '0;
    @(negedge clk);
    nopm(1'b0); nopm(1'b0);
    chk("rst_dq", dq, ZV);
    rst = 1'b0;

    // Fill bank 1 row 0x012, cols 4..7,0..3 with 0x1111..0x8888
    cmd(LMR, 2'd0, 12'h033);
    cmd(ACT, 2'd1, 12'h012);
    drive(WR, 2'd1, 12'h004, 2'b00, 1'b1, 16'h1111);
    for (int i = 1; i < 8; i++) drive(NOP, 2'd0, 12'h0, 2'b00, 1'b1, 16'(16'h1111 * (i + 1)));
    nopm(1'b0);

    cmd(RD, 2'd1, 12'h004);
    e = '{16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555, 16'h6666, 16'h7777, 16'h8888};
    expect_seq("rd_seq4", 3, 8, e, -1);

    cmd(RD, 2'd1, 12'h006);
    e = '{16'h3333, 16'h4444, 16'h5555, 16'h6666, 16'h7777, 16'h8888, 16'h1111, 16'h2222};
    expect_seq("rd_seq6", 3, 8, e, -1);

    cmd(RD, 2'd1, 12'h004);
    e = '{16'h1111, 16'h2222, ZV, 16'h4444, 16'h5555, 16'h6666, 16'h7777, 16'h8888};
    expect_seq("rd_dqm", 3, 8, e, 3);

    cmd(PRE, 2'd0, 12'h400);
    cmd(LMR, 2'd0, 12'h03B);
    cmd(ACT, 2'd1, 12'h012);
    cmd(RD, 2'd1, 12'h006);
    e = '{16'h3333, 16'h4444, 16'h1111, 16'h2222, 16'h7777, 16'h8888, 16'h5555, 16'h6666};
    expect_seq("rd_il6", 3, 8, e, -1);

    // BL=1 with single-word writes; upper byte masked on the second write
    cmd(PRE, 2'd0, 12'h400);
    cmd(LMR, 2'd0, 12'h230);
    cmd(ACT, 2'd2, 12'h345);
    drive(WR, 2'd2, 12'h020, 2'b00, 1'b1, 16'h1234);
    drive(WR, 2'd2, 12'h020, 2'b10, 1'b1, 16'hABCD);
    nopm(1'b0);
    cmd(RD, 2'd2, 12'h020);
    e[0] = 16'h12CD;
    expect_seq("rd_bytemask", 3, 1, e, -1);

    // CL=2, second READ four edges later truncates the first
    cmd(PRE, 2'd0, 12'h400);
    cmd(LMR, 2'd0, 12'h023);
    cmd(ACT, 2'd1, 12'h012);
    cmd(RD, 2'd1, 12'h004);
    chk("rd_trunc_z0", dq, ZV);
    t = '{16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555, 16'h6666,
          16'h7777, 16'h8888, 16'h1111, 16'h2222, 16'h3333, 16'h4444};
    for (int k = 1; k <= 13; k++) begin
      if (k == 4) cmd(RD, 2'd1, 12'h000);
      else        nopm(1'b0);
      x = ZV;
      if (k <= 12) x = t[k-1];
      chk($sformatf("rd_trunc_k%0d", k), dq, x);
    end

    // Auto-precharge closes the bank; the following READ is ignored
    cmd(RD, 2'd1, 12'h404);
    e = '{16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555, 16'h6666, 16'h7777, 16'h8888};
    expect_seq("rd_ap", 2, 8, e, -1);
    cmd(RD, 2'd1, 12'h004);
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("rd_idle_k%0d", k), dq, ZV);
      nopm(1'b0);
    end

    // Reset in the middle of a read burst
    cmd(ACT, 2'd1, 12'h012);
    cmd(RD, 2'd1, 12'h004);
    nopm(1'b0); chk("rst_pre_b0", dq, 16'h1111);
    nopm(1'b0); chk("rst_pre_b1", dq, 16'h2222);
    rst = 1'b1;
    nopm(1'b0); chk("rst_mid_z", dq, ZV);
    nopm(1'b0); chk("rst_hold_z", dq, ZV);
    rst = 1'b0;

    // Default mode after reset (CL=3, BL=8) and retained contents
    cmd(ACT, 2'd1, 12'h012);
    cmd(RD, 2'd1, 12'h004);
    expect_seq("rd_after_rst", 3, 8, e, -1);

    // Burst terminate after two issued beats
    cmd(RD, 2'd1, 12'h004); chk("bt_z0", dq, ZV);
    nopm(1'b0);             chk("bt_z1", dq, ZV);
    cmd(BT, 2'd0, 12'h0);   chk("bt_b0", dq, 16'h1111);
    nopm(1'b0);             chk("bt_b1", dq, 16'h2222);
    nopm(1'b0);             chk("bt_z2", dq, ZV);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
